fir_alu_sequencer: RTL and testbench

Upstream controller for the 5-stage integer ALU in the FIR test path. It holds the tap coefficients and the sample delay line. For each accepted input sample it issues signed multiplies and then serial accumulating adds to the ALU, and captures the ALU results by cycle count. It returns one filtered output per input sample over a valid/ready interface.

---
 rtl/fir_alu_sequencer_if.sv | 30 +++
 rtl/fir_alu_sequencer.sv | 130 +++++++++++++
 tb/tb_fir_alu_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_alu_sequencer_if.sv
// Bus bundle for the FIR sequencer: coefficient writes, sample in, result out,
// and the issue/result path to the external pipelined ALU.
interface fir_alu_sequencer_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 5
);
  logic                  coef_we;
  logic [AWIDTH-1:0]     coef_addr;
  logic [DWIDTH-1:0]     coef_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DWIDTH-1:0]     s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [2*DWIDTH+5:0]   m_data;
  logic [2:0]            alu_opcode;
  logic [2*DWIDTH+4:0]   alu_a;
  logic [2*DWIDTH+4:0]   alu_b;
  logic [2*DWIDTH+5:0]   alu_y;

  modport slave (
    input  coef_we, coef_addr, coef_data, s_valid, s_data, m_ready, alu_y,
    output s_ready, m_valid, m_data, alu_opcode, alu_a, alu_b
  );

  modport master (
    output coef_we, coef_addr, coef_data, s_valid, s_data, m_ready, alu_y,
    input  s_ready, m_valid, m_data, alu_opcode, alu_a, alu_b
  );
endinterface

// File: rtl/fir_alu_sequencer.sv
// FIR controller: per sample, issues NTAPS multiplies then NTAPS-1 serial adds to
// an external ALU_LAT-deep ALU, capturing results purely by cycle count.
module fir_alu_sequencer #(
  parameter int DWIDTH  = 16,
  parameter int NTAPS   = 8,
  parameter int AWIDTH  = 5,
  parameter int ALU_LAT = 4
) (
  input logic             clk,
  input logic             rst_n,
  fir_alu_sequencer_if.slave bus
);
  localparam int PW = 2*DWIDTH + 5;
  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int CW = $clog2(NTAPS + ALU_LAT + 1) + 1;
  localparam logic [CW-1:0]     MUL_END   = CW'(NTAPS);
  localparam logic [CW-1:0]     CAP_FIRST = CW'(ALU_LAT + 1);
  localparam logic [CW-1:0]     CAP_END   = CW'(NTAPS + ALU_LAT);
  localparam logic [CW-1:0]     ADD_END   = CW'(ALU_LAT);
  localparam logic [IW-1:0]     LAST_TAP  = IW'(NTAPS - 1);
  localparam logic [AWIDTH:0]   NT_A      = (AWIDTH+1)'(NTAPS);

  typedef enum logic [2:0] {IDLE, MUL, WAITP, ADD, OUT} state_t;
  state_t state, state_nx;

  logic [DWIDTH-1:0] c [NTAPS];
  logic [DWIDTH-1:0] x [NTAPS];
  logic [PW-1:0]     p [NTAPS];
  logic [PW-1:0]     acc, y;
  logic [CW-1:0]     cnt, mi, ci;
  logic [IW-1:0]     j;
  logic              cap, prod_done, add_done;
  logic              unused_y_msb;

  // The ALU result top bit is only a carry that always equals the sign here.
  assign y            = bus.alu_y[PW-1:0];
  assign unused_y_msb = bus.alu_y[PW];

  // cnt counts cycles since accept during MUL/WAITP, and the add phase in ADD.
  assign mi        = cnt - CW'(1);
  assign ci        = cnt - CAP_FIRST;
  assign cap       = (state == MUL || state == WAITP) && cnt >= CAP_FIRST && cnt <= CAP_END;
  assign prod_done = (state == MUL || state == WAITP) && cnt == CAP_END;
  assign add_done  = (state == ADD) && cnt == ADD_END;

  function automatic logic [PW-1:0] sext(input logic [DWIDTH-1:0] v);
    return {{(PW-DWIDTH){v[DWIDTH-1]}}, v};
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx       = state;
    bus.alu_opcode = 3'b000;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.s_ready    = (state == IDLE);
    bus.m_valid    = (state == OUT);
    bus.m_data     = {acc[PW-1], acc};
    case (state)
      IDLE: if (bus.s_valid) state_nx = MUL;
      MUL, WAITP: begin
        if (state == MUL) begin
          bus.alu_opcode = 3'b001;
          bus.alu_a      = sext(x[mi[IW-1:0]]);
          bus.alu_b      = sext(c[mi[IW-1:0]]);
        end
        if (prod_done)                        state_nx = (NTAPS == 1) ? OUT : ADD;
        else if (state == MUL && cnt == MUL_END) state_nx = WAITP;
      end
      ADD: begin
        if (cnt == '0) begin
          bus.alu_opcode = 3'b011;
          bus.alu_a      = acc;
          bus.alu_b      = p[j];
        end
        if (add_done && j == LAST_TAP) state_nx = OUT;
      end
      OUT:     if (bus.m_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        c[k] <= '0;
        x[k] <= '0;
        p[k] <= '0;
      end
      acc <= '0;
      cnt <= '0;
      j   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Same-cycle coefficient write and accept both land before MUL reads c[].
          if (bus.coef_we && {1'b0, bus.coef_addr} < NT_A)
            c[bus.coef_addr[IW-1:0]] <= bus.coef_data;
          if (bus.s_valid) begin
            x[0] <= bus.s_data;
            for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            cnt <= CW'(1);
          end
        end
        MUL, WAITP: begin
          cnt <= cnt + CW'(1);
          if (cap) p[ci[IW-1:0]] <= y;
          if (prod_done) begin
            acc <= (NTAPS == 1) ? y : p[0];
            cnt <= '0;
            j   <= IW'(1);
          end
        end
        ADD: begin
          if (add_done) begin
            acc <= y;
            cnt <= '0;
            j   <= j + IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_alu_sequencer.sv
// Scoreboard bench: behavioural ALU pipe, dot-product reference model, and a
// decoupled monitor checking data, latency and the per-sample opcode pattern.
module tb_fir_alu_sequencer;
  localparam int DW = 16, NT = 8, AW = 5, LAT = 4;
  localparam int YW = 2*DW + 6;
  localparam int L  = NT + LAT + 1 + (NT-1)*(LAT+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_alu_sequencer_if #(.DWIDTH(DW), .AWIDTH(AW)) bus();

  fir_alu_sequencer #(.DWIDTH(DW), .NTAPS(NT), .AWIDTH(AW), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural ALU: ALU_LAT-deep, result combinational at the end
  logic [YW-1:0] apipe [LAT];
  logic [YW-1:0] garb;
  logic          garbage = 1'b0;
  function automatic longint sx(input logic [YW-2:0] v);
    return longint'($signed(v));
  endfunction
  always @(posedge clk) begin : alu_model
    logic [YW-1:0] r;
    case (bus.alu_opcode)
      3'b001:  r = YW'(longint'($signed(bus.alu_a[DW-1:0])) * longint'($signed(bus.alu_b[DW-1:0])));
      3'b011:  r = YW'(sx(bus.alu_a) + sx(bus.alu_b));
      default: r = YW'({$urandom, $urandom});
    endcase
    for (int i = LAT-1; i > 0; i--) apipe[i] <= apipe[i-1];
    apipe[0] <= r;
    garb     <= YW'({$urandom, $urandom});
  end
  assign bus.alu_y = garbage ? garb : apipe[LAT-1];

  // ---------------- m_ready driver (mid-cycle, away from both edges)
  bit rand_ready = 1'b0, mr_force = 1'b1;
  always @(posedge clk) begin
    #2;
    bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : mr_force;
  end

  // ---------------- reference model: FIR is a dot product of taps and history
  longint cm [NT];
  longint xm [NT];
  longint expq[$];
  int     accq[$];
  int     cyc = 0, acc_seq = 0, last_acc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NT; k++) begin cm[k] = 0; xm[k] = 0; end
    end else begin
      if (bus.s_ready && bus.coef_we && int'(bus.coef_addr) < NT)
        cm[int'(bus.coef_addr)] = longint'($signed(bus.coef_data));
      if (bus.s_valid && bus.s_ready) begin
        longint s;
        for (int k = NT-1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = longint'($signed(bus.s_data));
        s = 0;
        for (int k = 0; k < NT; k++) s += cm[k] * xm[k];
        expq.push_back(s);
        accq.push_back(cyc);
        last_acc = cyc;
        acc_seq++;
      end
      cyc++;
    end
  end

  function automatic int exp_op(input int rel);
    int r;
    if (rel <= NT) return 1;
    if (rel <= NT + LAT) return 0;
    r = rel - (NT + LAT + 1);
    if (r % (LAT+1) == 0 && r / (LAT+1) < NT-1) return 3;
    return 0;
  endfunction

  // ---------------- monitor
  bit     in_out = 1'b0, trk = 1'b0;
  int     seen_seq = 0, bad_rel = 0;
  longint held;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expq.delete();
      accq.delete();
      in_out   = 1'b0;
      trk      = 1'b0;
      seen_seq = acc_seq;
    end else begin
      if (acc_seq != seen_seq) begin
        seen_seq = acc_seq;
        trk      = 1'b1;
        bad_rel  = 0;
      end
      if (trk) begin
        int rel;
        rel = cyc - last_acc;
        if (rel >= 1 && rel <= L && bad_rel == 0 && int'(bus.alu_opcode) != exp_op(rel))
          bad_rel = rel;
      end
      if (bus.m_valid) begin
        if (!in_out) begin
          in_out = 1'b1;
          trk    = 1'b0;
          held   = longint'($signed(bus.m_data));
          if (expq.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            longint e;
            int     a;
            e = expq.pop_front();
            a = accq.pop_front();
            chk("m_data", longint'($signed(bus.m_data)), e);
            chk("latency", cyc - a, L);
            chk("op_trace_first_bad_cycle", bad_rel, 0);
          end
        end else begin
          chk("m_data_hold", longint'($signed(bus.m_data)), held);
        end
        if (bus.m_ready) in_out = 1'b0;
      end
    end
  end

  // ---------------- stimulus
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.s_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("s_ready_timeout", n, 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit wc = 1'b0,
                      input logic [AW-1:0] a = '0, input logic [DW-1:0] cd = '0);
    wait_ready();
    bus.s_valid = 1'b1; bus.s_data = d;
    bus.coef_we = wc;   bus.coef_addr = a; bus.coef_data = cd;
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.coef_we = 1'b0;
  endtask

  task automatic coef_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic coef_raw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || in_out) && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("drain_timeout", n, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 1);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_data"},  longint'(bus.m_data), 0);
    chk({tag, "_opcode"},  bus.alu_opcode, 0);
    chk({tag, "_alu_a"},   longint'(bus.alu_a), 0);
    chk({tag, "_alu_b"},   longint'(bus.alu_b), 0);
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    #13;
    chk_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;

    // all-zero taps
    send(16'd1234);
    drain();

    // ramp taps with impulse: 100, 200, ... 800
    for (int k = 0; k < NT; k++) coef_write(AW'(k), DW'(k+1));
    send(16'd100);
    for (int i = 0; i < NT-1; i++) send(16'd0);
    drain();

    // full-scale negative corner: 8 * 2^30, positive, no wrap
    for (int k = 0; k < NT; k++) coef_write(AW'(k), 16'h8000);
    for (int i = 0; i < NT; i++) send(16'h8000);
    drain();

    // back-pressure: output held, input ignored
    mr_force = 1'b0;
    send(16'd321);
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.m_valid && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("m_valid_timeout", n, 0);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b1; bus.s_data = DW'($urandom);
      chk("s_ready_while_held", bus.s_ready, 0);
    end
    bus.s_valid = 1'b0;
    mr_force = 1'b1;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    chk("s_ready_after_handshake", bus.s_ready, 1);
    chk("m_valid_after_handshake", bus.m_valid, 0);
    drain();

    // busy coefficient write and out-of-range address are both dropped
    send(16'd50);
    repeat (10) @(negedge clk);
    coef_raw(5'd0, 16'd7);
    drain();
    coef_write(5'd9, 16'd555);
    send(16'd60);
    send(16'hFFF0);
    drain();

    // random taps, samples, back-pressure, and write-with-accept
    rand_ready = 1'b1;
    for (int k = 0; k < NT; k++) coef_write(AW'(k), DW'($urandom));
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0)
        send(DW'($urandom), 1'b1, AW'($urandom_range(0, 9)), DW'($urandom));
      else
        send(DW'($urandom));
    end
    drain();
    rand_ready = 1'b0;

    // reset in the middle of the add phase, then garbage on alu_y
    send(16'd1000);
    repeat (25) @(negedge clk);
    #2 rst_n = 1'b0; garbage = 1'b1;
    #1 chk_reset_vals("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 garbage = 1'b0;
    for (int k = 0; k < NT; k++) coef_write(AW'(k), DW'(3*k - 5));
    send(16'd200);
    send(16'd0);
    drain();

    chk("scoreboard_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
